// File: rtl/cache_invalidate_receiver_if.sv
// Bundle of the invalidate input, CPU lookup probe and tag-array port seen by one
// cache_invalidate_receiver; the master side is the environment, the slave side the receiver.
interface cache_invalidate_receiver_if #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 4,
    parameter int DEPTH    = 4
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               inv_valid;
    logic [ADDR_W-1:0]  inv_addr;
    logic [ADDR_W-1:0]  cpu_addr;
    logic               pending_match;
    logic               tag_req;
    logic               tag_gnt;
    logic [INDEX_W-1:0] tag_index;
    logic [TAG_W-1:0]   tag_rd_tag;
    logic               tag_rd_valid;
    logic               tag_clr;
    logic               overflow;
    logic [CNT_W-1:0]   inv_count;

    modport master (
        output inv_valid, inv_addr, cpu_addr, tag_gnt, tag_rd_tag, tag_rd_valid,
        input  pending_match, tag_req, tag_index, tag_clr, overflow, inv_count
    );

    modport slave (
        input  inv_valid, inv_addr, cpu_addr, tag_gnt, tag_rd_tag, tag_rd_valid,
        output pending_match, tag_req, tag_index, tag_clr, overflow, inv_count
    );
endinterface

// File: rtl/cache_invalidate_receiver.sv
// Coherence invalidate endpoint: queues peer-write invalidates, drains them into the local
// tag array, and sweeps the whole array when the queue overflows.
module cache_invalidate_receiver #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 4,
    parameter int DEPTH    = 4
) (
    input logic                        clock,
    input logic                        reset,
    cache_invalidate_receiver_if.slave bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, SWEEP} state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [INDEX_W-1:0] sweep_idx;

    logic [INDEX_W-1:0] head_index;
    logic [TAG_W-1:0]   head_tag;
    logic               pop, drop, push, sweep_step, sweep_done;
    logic               tag_req, tag_clr, pending_match;
    logic [INDEX_W-1:0] tag_index;

    assign head_index = mem[rd_ptr][OFFSET_W +: INDEX_W];
    assign head_tag   = mem[rd_ptr][ADDR_W-1 -: TAG_W];

    // A full queue only loses an address when the drain is not freeing a slot this cycle.
    assign pop        = (state == CHECK);
    assign drop       = bus.inv_valid && (count == CNT_W'(DEPTH)) && !pop;
    assign push       = bus.inv_valid && !drop;
    assign sweep_step = (state == SWEEP) && bus.tag_gnt;
    assign sweep_done = sweep_step && (sweep_idx == '1);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tag_req    = 1'b0;
        tag_index  = '0;
        tag_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (overflow)          state_next = SWEEP;
                else if (count != '0)  state_next = LOOKUP;
            end
            LOOKUP: begin
                tag_req   = 1'b1;
                tag_index = head_index;
                if (bus.tag_gnt) state_next = CHECK;
            end
            CHECK: begin
                tag_req    = 1'b1;
                tag_index  = head_index;
                tag_clr    = bus.tag_rd_valid && (bus.tag_rd_tag == head_tag);
                state_next = IDLE;
            end
            SWEEP: begin
                tag_req   = 1'b1;
                tag_index = sweep_idx;
                tag_clr   = bus.tag_gnt;
                if (sweep_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A dropped address restarts the full sweep, even if one is already under way.
        if (drop) state_next = SWEEP;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            sweep_idx <= '0;
        end else if (drop) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b1;
            sweep_idx <= '0;
        end else begin
            if (push)       wr_ptr    <= wr_ptr + 1'b1;
            if (pop)        rd_ptr    <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (sweep_step) sweep_idx <= sweep_idx + 1'b1;
            if (sweep_done) overflow  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.inv_addr;
    end

    // Offset bits are masked out by the shift so any byte in the line collides.
    always_comb begin
        pending_match = (state == SWEEP) || overflow;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) &&
                (((mem[rd_ptr + PTR_W'(i)] ^ bus.cpu_addr) >> OFFSET_W) == '0))
                pending_match = 1'b1;
        end
    end

    assign bus.tag_req       = tag_req;
    assign bus.tag_index     = tag_index;
    assign bus.tag_clr       = tag_clr;
    assign bus.overflow      = overflow;
    assign bus.inv_count     = count;
    assign bus.pending_match = pending_match;
endmodule

// File: tb/tb_cache_invalidate_receiver.sv
// Randomized bench for cache_invalidate_receiver: a queue-based transaction model plus a
// behavioural tag array predicts every output each cycle.
module tb_cache_invalidate_receiver;
    localparam int ADDR_W   = 16;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 4;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cache_invalidate_receiver_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
                                   .INDEX_W(INDEX_W), .DEPTH(DEPTH)) bus ();

    cache_invalidate_receiver #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W),
                                .INDEX_W(INDEX_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending addresses, overflow flag, sweep position (-1 = none),
    // drain progress of the head (0 none, 1 waiting for grant, 2 data returning).
    logic [ADDR_W-1:0] q [$];
    bit                ovf;
    int                sweep;
    int                drain;

    logic [TAG_W-1:0]  arr_tag [LINES];
    bit                arr_vld [LINES];
    logic [ADDR_W-1:0] last_addr;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        else             n_pass++;
    endtask

    function automatic int line_index(input logic [ADDR_W-1:0] a);
        return int'((a >> OFFSET_W) % LINES);
    endfunction

    function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFFSET_W + INDEX_W));
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [TAG_W-1:0]    t;
        logic [INDEX_W-1:0]  i;
        logic [OFFSET_W-1:0] o;
        t = TAG_W'(32'h48 + $urandom_range(0, 1));
        i = INDEX_W'($urandom_range(0, LINES - 1));
        o = OFFSET_W'($urandom_range(0, 3));
        return {t, i, o};
    endfunction

    task automatic model_reset();
        q.delete();
        ovf   = 1'b0;
        sweep = -1;
        drain = 0;
    endtask

    // One clock: drive inputs at negedge, compare outputs, advance model and tag array.
    task automatic cycle(input bit rst_n, input bit iv, input logic [ADDR_W-1:0] ia,
                         input logic [ADDR_W-1:0] ca, input bit g);
        int               idx, sz;
        bit               eclr, pm, pop, drop;
        logic [TAG_W-1:0] nxt_tag;
        bit               nxt_vld;
        @(negedge clock);
        reset         = rst_n;
        bus.inv_valid = iv;
        bus.inv_addr  = ia;
        bus.cpu_addr  = ca;
        bus.tag_gnt   = g;
        #1;
        idx  = 0;
        eclr = 1'b0;
        if (drain != 0) begin
            idx = line_index(q[0]);
            if (drain == 2) eclr = bus.tag_rd_valid && (bus.tag_rd_tag == line_tag(q[0]));
        end else if (sweep >= 0) begin
            idx  = sweep;
            eclr = g;
        end
        pm = ovf || (sweep >= 0);
        foreach (q[i]) if ((q[i] >> OFFSET_W) == (ca >> OFFSET_W)) pm = 1'b1;

        check_val("tag_req",       32'(bus.tag_req),       32'(drain != 0 || sweep >= 0));
        check_val("tag_index",     32'(bus.tag_index),     32'(idx));
        check_val("tag_clr",       32'(bus.tag_clr),       32'(eclr));
        check_val("overflow",      32'(bus.overflow),      32'(ovf));
        check_val("inv_count",     32'(bus.inv_count),     32'(q.size()));
        check_val("pending_match", 32'(bus.pending_match), 32'(pm));

        nxt_tag = arr_tag[idx];
        nxt_vld = arr_vld[idx];
        if (eclr) arr_vld[idx] = 1'b0;
        if ($urandom_range(0, 15) == 0) begin
            int r = $urandom_range(0, LINES - 1);
            arr_tag[r] = TAG_W'(32'h48 + $urandom_range(0, 1));
            arr_vld[r] = 1'b1;
        end

        if (!rst_n) model_reset();
        else begin
            sz   = q.size();
            pop  = (drain == 2);
            drop = iv && (sz == DEPTH) && !pop;
            if (drop) begin
                q.delete();
                ovf   = 1'b1;
                sweep = 0;
                drain = 0;
            end else begin
                if (pop) begin
                    q.delete(0);
                    drain = 0;
                end else if (drain == 1) begin
                    if (g) drain = 2;
                end else if (sweep >= 0) begin
                    if (g) begin
                        if (sweep == LINES - 1) begin
                            sweep = -1;
                            ovf   = 1'b0;
                        end else sweep++;
                    end
                end else if (ovf) sweep = 0;
                else if (sz > 0) drain = 1;
                if (iv) q.push_back(ia);
            end
        end

        @(posedge clock);
        #1;
        bus.tag_rd_tag   = nxt_tag;
        bus.tag_rd_valid = nxt_vld;
    endtask

    initial begin
        bus.inv_valid    = 1'b0;
        bus.inv_addr     = '0;
        bus.cpu_addr     = '0;
        bus.tag_gnt      = 1'b0;
        bus.tag_rd_tag   = '0;
        bus.tag_rd_valid = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            arr_tag[i] = TAG_W'(32'h48 + $urandom_range(0, 1));
            arr_vld[i] = ($urandom_range(0, 1) == 1);
        end
        last_addr = 16'h1234;
        model_reset();
        repeat (2) @(posedge clock);

        // Reset held: outputs must already be quiet.
        cycle(1'b0, 1'b0, '0, '0, 1'b0);

        // Matching line invalidated with immediate grant.
        arr_tag[13] = 10'h048;
        arr_vld[13] = 1'b1;
        cycle(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, '0, 16'h1234, 1'b1);

        // Same index holds a different tag: checked and popped without a clear.
        arr_tag[13] = 10'h049;
        arr_vld[13] = 1'b1;
        cycle(1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1);
        repeat (4) cycle(1'b1, 1'b0, '0, 16'h0000, 1'b1);

        // Fill with grant withheld, probe a queued line, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, ADDR_W'(i * 16), 16'h0022, 1'b0);
        cycle(1'b1, 1'b0, '0, 16'h0022, 1'b0);
        repeat (14) cycle(1'b1, 1'b0, '0, 16'h0022, 1'b1);

        // Overflow on a full queue, then a complete sweep.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, ADDR_W'(i * 16), 16'h0100, 1'b0);
        cycle(1'b1, 1'b1, 16'h0050, 16'h0100, 1'b0);
        cycle(1'b1, 1'b0, '0, 16'h0100, 1'b0);
        repeat (18) cycle(1'b1, 1'b0, '0, 16'h0100, 1'b1);

        // Full queue with a pop coinciding with a push: no overflow.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, ADDR_W'(i * 16), 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, '0, 16'h0000, 1'b1);
        cycle(1'b1, 1'b1, 16'h0060, 16'h0060, 1'b1);
        repeat (20) cycle(1'b1, 1'b0, '0, 16'h0060, 1'b1);

        // Reset in the middle of a sweep at index 7.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, ADDR_W'(i * 16), 16'h0000, 1'b0);
        repeat (7) cycle(1'b1, 1'b0, '0, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, '0, 16'h0000, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, '0, 16'h0000, 1'b1);

        // Random traffic with alternating grant-rich and grant-starved phases.
        for (int n = 0; n < 3000; n++) begin
            logic [ADDR_W-1:0] a, c;
            bit                iv, g;
            a  = rand_addr();
            c  = ($urandom_range(0, 1) == 1) ? (last_addr ^ ADDR_W'($urandom_range(0, 3)))
                                             : rand_addr();
            iv = ($urandom_range(0, 2) == 0);
            g  = ((n / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (iv) last_addr = a;
            cycle(($urandom_range(0, 499) != 0), iv, a, c, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
